sdm_stream_ctrl: RTL and testbench
==================================

Name: sdm_stream_ctrl

Overview:
Sample-rate scheduler and stream buffer in front of the SDM DAC/ADC pair in top.
- Accepts host PCM samples on a valid/ready stream into a small FIFO.
- Releases one sample to the DAC every OSR clocks.
- Sequences enable, warm-up and drain.
- Forwards decimated ADC samples to the host through a holding register, with underrun and overrun tracking.

Parameters:
DATA_W, 16, PCM sample width (signed two's complement)
OSR, 64, clocks per audio sample; legal range 2..1024
FIFO_DEPTH, 8, DAC-side FIFO entries; power of two, >=2
SETTLE_SAMPLES, 4, sample ticks spent in WARMUP before RUN; >=1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; start/stop streaming
s_valid  in  1  host sample valid
s_ready  out  1  FIFO can accept a host sample
s_data  in  DATA_W  host PCM sample
dac_valid  out  1  one-cycle strobe; dac_audio is new (drives valid_in_dac)
dac_audio  out  DATA_W  sample to DAC (drives audio_in)
adc_valid  in  1  decimator sample strobe (valid_out_adc)
adc_audio  in  DATA_W  decimator sample (audio_out)
m_valid  out  1  host ADC sample available
m_ready  in  1  host takes ADC sample
m_data  out  DATA_W  host ADC sample
busy  out  1  state != IDLE
underrun  out  1  sticky: tick in RUN with FIFO empty
overrun  out  1  sticky: ADC sample overwrote an unconsumed m_data
clr_flags  in  1  synchronous clear of sticky flags

Behaviour:
- Reset: all outputs 0, FIFO empty, tick counter 0, state IDLE.
- Tick counter: 0..OSR-1 while state != IDLE; held at 0 in IDLE.
  - tick = (cnt == OSR-1), then wrap to 0.
  - First tick comes OSR cycles after leaving IDLE.
- States:
  - IDLE: enable=1 -> WARMUP.
  - WARMUP: dac_audio forced 0 at each tick. After SETTLE_SAMPLES ticks -> RUN. enable=0 -> IDLE next cycle, FIFO flushed.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: enable=1 -> RUN. At a tick with FIFO empty -> IDLE; no dac_valid pulse for that tick.
- s_ready = !full && state in {WARMUP, RUN}. Push on s_valid && s_ready. Host may preload during WARMUP.
- DAC path, registered:
  - A tick in WARMUP/RUN/DRAIN (except the DRAIN-exit tick) gives dac_valid=1 on the next cycle.
  - dac_audio updates in that same cycle.
  - In RUN/DRAIN a non-empty FIFO pops its head into dac_audio.
  - RUN with FIFO empty: dac_audio holds its last value and underrun sets.
- FIFO occupancy:
  - Push and pop in the same cycle leaves occupancy unchanged. This is legal when full, because s_ready is computed before the pop.
  - Pointers wrap modulo FIFO_DEPTH.
- ADC path: adc_valid is ignored in IDLE/WARMUP (decimator settling). In RUN/DRAIN, adc_valid loads m_data and sets m_valid.
  - m_valid && m_ready with no adc_valid: m_valid clears.
  - adc_valid with m_valid=1 and m_ready=0: m_data overwritten and overrun sets.
  - adc_valid together with m_ready: new data loads, m_valid stays 1, no overrun.
- Sticky flags: clr_flags clears them. If clr_flags and a set event occur in the same cycle, set wins.
- Returning to IDLE: m_valid is held until consumed, and m_data stays stable.
- Asynchronous reset mid-stream: immediate return to the reset values; FIFO contents are lost.

Optional Feature:
SDM_CTRL_STATS_EN
- Defined:
  - Adds outputs underrun_cnt[15:0] and overrun_cnt[15:0].
  - Each increments on its event and saturates at 16'hFFFF.
  - clr_flags zeroes both counters.
- Undefined: these ports and counters are absent; the sticky flags are unchanged.

Decomposition:
- sdm_ctrl_pkg:
  - state enum: IDLE, WARMUP, RUN, DRAIN.
  - localparam-derived widths: CNT_W = $clog2(OSR), PTR_W = $clog2(FIFO_DEPTH).
  - Default DATA_W.
- Sub-module sdm_ctrl_fifo:
  - Synchronous FIFO with push/pop, full/empty and count.
  - First-word head visible combinationally.
- Top level holds the FSM, tick counter, DAC register and ADC holding register.

Test Plan (OSR=4, FIFO_DEPTH=4, SETTLE_SAMPLES=2):
- enable=1 from reset -> busy=1 next cycle; dac_valid pulses every 4 clocks with dac_audio=0; first two pulses occur in WARMUP; RUN is entered after the second tick.
- Preload 0x1111, 0x2222, 0x3333, 0x4444 in WARMUP -> s_ready=0 after the 4th push; in RUN the dac_audio sequence is 1111, 2222, 3333, 4444, one per tick.
- FIFO empty at a RUN tick after 0x4444 -> dac_audio stays 0x4444 and underrun=1; clr_flags -> underrun=0.
- adc_valid 0x0AAA then 0x0BBB with m_ready=0 -> m_data=0x0BBB and overrun=1; adc_valid with m_ready=1 in the same cycle -> no overrun.
- enable=0 with 2 words queued -> DRAIN; two more dac_valid pulses; IDLE at the following tick; s_ready=0 throughout DRAIN.
- rst_n low mid-RUN with 3 words queued -> all outputs 0 immediately; after release, FIFO empty and state IDLE.

Source files
------------

// File: rtl/sdm_ctrl_pkg.sv
// Shared types and defaults for the SDM stream controller.
// The optional statistics counters are enabled with SDM_CTRL_STATS_EN.
package sdm_ctrl_pkg;

    localparam int DEF_DATA_W         = 16;
    localparam int DEF_OSR            = 64;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_SETTLE_SAMPLES = 4;

    localparam int CNT_W = $clog2(DEF_OSR);
    localparam int PTR_W = $clog2(DEF_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdm_ctrl_fifo.sv
// Synchronous FIFO for host PCM samples; head word is visible combinationally.
// Pointers wrap naturally because DEPTH is a power of two.
module sdm_ctrl_fifo
    import sdm_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head,
    output logic                      full,
    output logic                      empty,
    output logic [width_of(DEPTH):0]  count
);

    localparam int PW = width_of(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/sdm_stream_ctrl.sv
// Sample-rate scheduler and stream buffer between host and the SDM DAC/ADC pair.
// Define SDM_CTRL_STATS_EN to add saturating underrun/overrun event counters.
module sdm_stream_ctrl
    import sdm_ctrl_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int OSR            = DEF_OSR,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              dac_valid,
    output logic [DATA_W-1:0] dac_audio,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_audio,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              underrun,
    output logic              overrun,
    input  logic              clr_flags
`ifdef SDM_CTRL_STATS_EN
    ,
    output logic [15:0]       underrun_cnt,
    output logic [15:0]       overrun_cnt
`endif
);

    localparam int TICK_W = width_of(OSR);
    localparam int SET_W  = width_of(SETTLE_SAMPLES);
    localparam int AW     = width_of(FIFO_DEPTH);

    state_e              state_q;
    logic [TICK_W-1:0]   cnt_q, cnt_d;
    logic [SET_W-1:0]    settle_q;
    logic                dac_valid_q;
    logic [DATA_W-1:0]   dac_audio_q;
    logic                m_valid_q;
    logic [DATA_W-1:0]   m_data_q;
    logic                underrun_q;
    logic                overrun_q;

    logic                tick;
    logic                push, pop, flush;
    logic                drain_exit;
    logic                under_set, over_set;
    logic                adc_take;
    logic                fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_head;
    logic [AW:0]         fifo_count;

    // Both streams use valid/ready: a transfer happens on a clock edge where
    // valid and ready are both high; valid must not depend on ready.
    always_comb begin
        tick       = (state_q != IDLE) && (cnt_q == TICK_W'(OSR - 1));
        cnt_d      = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        s_ready    = !fifo_full && (state_q == WARMUP || state_q == RUN);
        push       = s_valid && s_ready;
        drain_exit = (state_q == DRAIN) && !enable && tick && fifo_empty;
        pop        = tick && !fifo_empty && (state_q == RUN || state_q == DRAIN);
        flush      = (state_q == WARMUP) && !enable;
        under_set  = tick && (state_q == RUN) && fifo_empty;
        adc_take   = adc_valid && (state_q == RUN || state_q == DRAIN);
        over_set   = adc_take && m_valid_q && !m_ready;
    end

    sdm_ctrl_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            settle_q    <= '0;
            dac_valid_q <= 1'b0;
            dac_audio_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dac_valid_q <= 1'b0;
            cnt_q       <= cnt_d;
            case (state_q)
                IDLE: begin
                    settle_q <= '0;
                    if (enable) state_q <= WARMUP;
                end
                WARMUP: begin
                    if (tick) begin
                        dac_valid_q <= 1'b1;
                        dac_audio_q <= '0;
                        settle_q    <= settle_q + 1'b1;
                    end
                    if (!enable) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (tick && settle_q == SET_W'(SETTLE_SAMPLES - 1)) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        dac_valid_q <= 1'b1;
                        if (!fifo_empty) dac_audio_q <= fifo_head;
                    end
                    if (!enable) state_q <= DRAIN;
                end
                DRAIN: begin
                    // The tick that finds the FIFO empty ends the stream silently.
                    if (tick && !drain_exit) begin
                        dac_valid_q <= 1'b1;
                        if (!fifo_empty) dac_audio_q <= fifo_head;
                    end
                    if (enable) begin
                        state_q <= RUN;
                    end else if (drain_exit) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (adc_take) begin
                m_data_q  <= adc_audio;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end

            if (under_set)      underrun_q <= 1'b1;
            else if (clr_flags) underrun_q <= 1'b0;
            if (over_set)       overrun_q  <= 1'b1;
            else if (clr_flags) overrun_q  <= 1'b0;
        end
    end

`ifdef SDM_CTRL_STATS_EN
    logic [15:0] under_cnt_q;
    logic [15:0] over_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            under_cnt_q <= '0;
            over_cnt_q  <= '0;
        end else begin
            if (clr_flags)
                under_cnt_q <= under_set ? 16'd1 : 16'd0;
            else if (under_set && under_cnt_q != 16'hFFFF)
                under_cnt_q <= under_cnt_q + 16'd1;
            if (clr_flags)
                over_cnt_q <= over_set ? 16'd1 : 16'd0;
            else if (over_set && over_cnt_q != 16'hFFFF)
                over_cnt_q <= over_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = under_cnt_q;
    assign overrun_cnt  = over_cnt_q;
`else
    // Without statistics only the sticky flags report events.
`endif

    assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= (AW+1)'(FIFO_DEPTH));

    assign busy      = (state_q != IDLE);
    assign dac_valid = dac_valid_q;
    assign dac_audio = dac_audio_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sdm_stream_ctrl.sv
// Directed bench for sdm_stream_ctrl with OSR=4, FIFO_DEPTH=4, SETTLE_SAMPLES=2.
module tb_sdm_stream_ctrl;
    import sdm_ctrl_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         adc_valid = 1'b0;
    logic [W-1:0] adc_audio = '0;
    logic         m_ready = 1'b0;
    logic         clr_flags = 1'b0;

    logic         s_ready;
    logic         dac_valid;
    logic [W-1:0] dac_audio;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         busy;
    logic         underrun;
    logic         overrun;

    int n_total = 0;
    int n_bad   = 0;
    int n;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    sdm_stream_ctrl #(
        .DATA_W         (W),
        .OSR            (4),
        .FIFO_DEPTH     (4),
        .SETTLE_SAMPLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .dac_valid (dac_valid),
        .dac_audio (dac_audio),
        .adc_valid (adc_valid),
        .adc_audio (adc_audio),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy),
        .underrun  (underrun),
        .overrun   (overrun),
        .clr_flags (clr_flags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance until dac_valid is seen; n = cycles taken, max_cyc+1 on timeout.
    task automatic wait_pulse(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!dac_valid && cyc <= max_cyc);
    endtask

    task automatic push_word(input logic [W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        check_val("push_ready", 32'(s_ready), 32'd1);
        exp_q.push_back(d);
        step();
        s_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dac_valid"}, 32'(dac_valid), 32'd0);
        check_val({tag, "_dac_audio"}, 32'(dac_audio), 32'd0);
        check_val({tag, "_m_valid"},   32'(m_valid),   32'd0);
        check_val({tag, "_m_data"},    32'(m_data),    32'd0);
        check_val({tag, "_busy"},      32'(busy),      32'd0);
        check_val({tag, "_s_ready"},   32'(s_ready),   32'd0);
        check_val({tag, "_underrun"},  32'(underrun),  32'd0);
        check_val({tag, "_overrun"},   32'(overrun),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        step();
        step();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("idle_busy", 32'(busy), 32'd0);

        // Warm-up with preload
        enable = 1'b1;
        step();
        check_val("en_busy", 32'(busy), 32'd1);
        check_val("en_s_ready", 32'(s_ready), 32'd1);
        check_val("en_dac_valid", 32'(dac_valid), 32'd0);
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        push_word(16'h4444);
        check_val("full_s_ready", 32'(s_ready), 32'd0);
        check_val("warm1_dv", 32'(dac_valid), 32'd1);
        check_val("warm1_audio", 32'(dac_audio), 32'd0);
        check_val("warm1_state", 32'(dut.state_q), 32'(WARMUP));
        wait_pulse(8, n);
        check_val("warm2_gap", 32'(n), 32'd4);
        check_val("warm2_audio", 32'(dac_audio), 32'd0);
        check_val("warm2_state", 32'(dut.state_q), 32'(RUN));
        check_val("warm2_s_ready", 32'(s_ready), 32'd0);

        // RUN playback of the preloaded words
        for (int i = 0; i < 4; i++) begin
            wait_pulse(8, n);
            check_val("run_gap", 32'(n), 32'd4);
            check_val("run_audio", 32'(dac_audio), 32'(exp_q.pop_front()));
            check_val("run_underrun", 32'(underrun), 32'd0);
        end
        wait_pulse(8, n);
        check_val("urun_gap", 32'(n), 32'd4);
        check_val("urun_audio", 32'(dac_audio), 32'h4444);
        check_val("urun_flag", 32'(underrun), 32'd1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check_val("urun_clr", 32'(underrun), 32'd0);

        // ADC holding register
        m_ready   = 1'b0;
        adc_valid = 1'b1;
        adc_audio = 16'h0AAA;
        step();
        check_val("adc1_valid", 32'(m_valid), 32'd1);
        check_val("adc1_data", 32'(m_data), 32'h0AAA);
        check_val("adc1_overrun", 32'(overrun), 32'd0);
        adc_audio = 16'h0BBB;
        step();
        check_val("adc2_data", 32'(m_data), 32'h0BBB);
        check_val("adc2_overrun", 32'(overrun), 32'd1);
        adc_valid = 1'b0;
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check_val("orun_clr", 32'(overrun), 32'd0);
        check_val("clr_vs_set_urun", 32'(underrun), 32'd1);
        check_val("adc_hold", 32'(m_valid), 32'd1);
        adc_valid = 1'b1;
        adc_audio = 16'h0CCC;
        m_ready   = 1'b1;
        step();
        adc_valid = 1'b0;
        m_ready   = 1'b0;
        check_val("adc3_data", 32'(m_data), 32'h0CCC);
        check_val("adc3_valid", 32'(m_valid), 32'd1);
        check_val("adc3_overrun", 32'(overrun), 32'd0);

        // Drain with two words queued
        wait_pulse(8, n);
        check_val("realign_gap", 32'(n), 32'd3);
        push_word(16'h5555);
        push_word(16'h6666);
        enable = 1'b0;
        step();
        check_val("drain_state", 32'(dut.state_q), 32'(DRAIN));
        check_val("drain_s_ready0", 32'(s_ready), 32'd0);
        wait_pulse(8, n);
        check_val("drain1_gap", 32'(n), 32'd1);
        check_val("drain1_audio", 32'(dac_audio), 32'(exp_q.pop_front()));
        check_val("drain_s_ready1", 32'(s_ready), 32'd0);
        wait_pulse(8, n);
        check_val("drain2_gap", 32'(n), 32'd4);
        check_val("drain2_audio", 32'(dac_audio), 32'(exp_q.pop_front()));
        for (int i = 1; i <= 4; i++) begin
            step();
            check_val("exit_dv", 32'(dac_valid), 32'd0);
            check_val("exit_s_ready", 32'(s_ready), 32'd0);
            check_val("exit_busy", 32'(busy), (i == 4) ? 32'd0 : 32'd1);
        end

        // IDLE keeps the unconsumed ADC sample and ignores the decimator
        check_val("idle_m_valid", 32'(m_valid), 32'd1);
        check_val("idle_m_data", 32'(m_data), 32'h0CCC);
        adc_valid = 1'b1;
        adc_audio = 16'h0DDD;
        step();
        adc_valid = 1'b0;
        check_val("idle_adc_ign", 32'(m_data), 32'h0CCC);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check_val("idle_consume", 32'(m_valid), 32'd0);
        check_val("idle_urun_sticky", 32'(underrun), 32'd1);

        // Restart, queue three words, then reset mid-RUN
        enable = 1'b1;
        step();
        adc_valid = 1'b1;
        adc_audio = 16'h7777;
        push_word(16'h0A01);
        adc_valid = 1'b0;
        check_val("warm_adc_ign", 32'(m_valid), 32'd0);
        push_word(16'h0A02);
        push_word(16'h0A03);
        wait_pulse(8, n);
        check_val("re_warm1_gap", 32'(n), 32'd1);
        wait_pulse(8, n);
        check_val("re_warm2_gap", 32'(n), 32'd4);
        check_val("re_run_state", 32'(dut.state_q), 32'(RUN));
        adc_valid = 1'b1;
        adc_audio = 16'h1234;
        step();
        adc_valid = 1'b0;
        check_val("pre_rst_m_data", 32'(m_data), 32'h1234);
        check_val("pre_rst_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        check_val("post_rst_busy", 32'(busy), 32'd0);
        step();
        wait_pulse(8, n);
        check_val("post_warm1_gap", 32'(n), 32'd4);
        wait_pulse(8, n);
        check_val("post_warm2_gap", 32'(n), 32'd4);
        check_val("post_urun_pre", 32'(underrun), 32'd0);
        wait_pulse(8, n);
        check_val("post_run_gap", 32'(n), 32'd4);
        check_val("post_run_audio", 32'(dac_audio), 32'd0);
        check_val("post_run_urun", 32'(underrun), 32'd1);
        enable = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
